// File: rtl/packet_codec_if.sv
// ============================================================================
// Module      : packet_codec_if
// Description : Node-side and line-side signal bundle of the packet codec.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface packet_codec_if;
  logic [28:0] Packet_From_Node;
  logic        enc_valid_in;
  logic [54:0] packet;
  logic        enc_valid_out;
  logic [54:0] RX_Data;
  logic        dec_valid_in;
  logic [3:0]  addr;
  logic [2:0]  pkt_type;
  logic [23:0] Packet_To_Node;
  logic        bad_decode;
  logic        corrected;
  logic        dec_valid_out;

  modport master (
    output Packet_From_Node, enc_valid_in, RX_Data, dec_valid_in,
    input  packet, enc_valid_out, addr, pkt_type, Packet_To_Node,
           bad_decode, corrected, dec_valid_out
  );

  modport slave (
    input  Packet_From_Node, enc_valid_in, RX_Data, dec_valid_in,
    output packet, enc_valid_out, addr, pkt_type, Packet_To_Node,
           bad_decode, corrected, dec_valid_out
  );
endinterface

`default_nettype wire

// File: rtl/packet_codec.sv
// ============================================================================
// Module      : packet_codec
// Description : Registered link-layer encoder/decoder: SYNC + 3x header copies
//               + SECDED Hamming(29,24) payload protection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module packet_codec #(
  parameter logic [3:0] SYNC      = 4'b1011,
  parameter logic [2:0] TYPE_DATA = 3'b100,
  parameter logic [2:0] TYPE_CTRL = 3'b001
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  packet_codec_if.slave  bus
);

  function automatic logic [4:0] syndrome(input logic [28:0] cw);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 29; i++)
      if (cw[5'(i)]) s = s ^ 5'(i + 1);
    return s;
  endfunction

  function automatic logic [28:0] scatter(input logic [23:0] pl);
    logic [28:0] cw;
    logic [4:0]  j;
    cw = '0;
    j  = '0;
    for (int p = 1; p <= 29; p++)
      if ((p & (p - 1)) != 0) begin
        cw[5'(p - 1)] = pl[j];
        j = j + 5'd1;
      end
    return cw;
  endfunction

  function automatic logic [23:0] gather(input logic [28:0] cw);
    logic [23:0] pl;
    logic [4:0]  j;
    pl = '0;
    j  = '0;
    for (int p = 1; p <= 29; p++)
      if ((p & (p - 1)) != 0) begin
        pl[j] = cw[5'(p - 1)];
        j = j + 5'd1;
      end
    return pl;
  endfunction

  // Encode: check bits start at zero, so the raw syndrome is exactly the
  // check-bit vector that zeroes the final syndrome.
  logic [28:0] enc_cw;
  logic [4:0]  enc_chk;
  logic [2:0]  enc_type;
  logic [54:0] packet_d;

  always_comb begin
    enc_cw      = scatter(bus.Packet_From_Node[23:0]);
    enc_chk     = syndrome(enc_cw);
    enc_cw[0]   = enc_chk[0];
    enc_cw[1]   = enc_chk[1];
    enc_cw[3]   = enc_chk[2];
    enc_cw[7]   = enc_chk[3];
    enc_cw[15]  = enc_chk[4];
    enc_type    = bus.Packet_From_Node[28] ? TYPE_DATA : TYPE_CTRL;
    packet_d    = {SYNC, {3{enc_type}}, {3{bus.Packet_From_Node[27:24]}},
                   ^enc_cw, enc_cw};
  end

  logic [2:0]  t2, t1, t0, type_d;
  logic [3:0]  a2, a1, a0, addr_d;
  logic [4:0]  dec_s;
  logic        dec_p, uncorr, fixed, vote_fix, bad_d, corr_d;
  logic [28:0] cw_fix;
  logic [23:0] payload_d;

  always_comb begin
    {t2, t1, t0} = bus.RX_Data[50:42];
    {a2, a1, a0} = bus.RX_Data[41:30];
    type_d   = (t2 & t1) | (t2 & t0) | (t1 & t0);
    addr_d   = (a2 & a1) | (a2 & a0) | (a1 & a0);
    vote_fix = (t2 != type_d) | (t1 != type_d) | (t0 != type_d) |
               (a2 != addr_d) | (a1 != addr_d) | (a0 != addr_d);
    dec_s    = syndrome(bus.RX_Data[28:0]);
    dec_p    = ^bus.RX_Data[29:0];
    cw_fix   = bus.RX_Data[28:0];
    if (dec_p && (dec_s != 5'd0) && (dec_s <= 5'd29))
      cw_fix[dec_s - 5'd1] = ~cw_fix[dec_s - 5'd1];
    uncorr   = dec_p ? (dec_s >= 5'd30) : (dec_s != 5'd0);
    fixed    = dec_p && (dec_s <= 5'd29);
    bad_d    = (bus.RX_Data[54:51] != SYNC) | uncorr |
               ((type_d != TYPE_DATA) && (type_d != TYPE_CTRL));
    corr_d   = fixed | vote_fix;
    // Unusable words expose the raw payload rather than a guessed repair.
    payload_d = bad_d ? gather(bus.RX_Data[28:0]) : gather(cw_fix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.packet         <= '0;
      bus.enc_valid_out  <= 1'b0;
      bus.addr           <= '0;
      bus.pkt_type       <= '0;
      bus.Packet_To_Node <= '0;
      bus.bad_decode     <= 1'b0;
      bus.corrected      <= 1'b0;
      bus.dec_valid_out  <= 1'b0;
    end else begin
      bus.enc_valid_out <= bus.enc_valid_in;
      bus.dec_valid_out <= bus.dec_valid_in;
      if (bus.enc_valid_in)
        bus.packet <= packet_d;
      if (bus.dec_valid_in) begin
        bus.addr           <= addr_d;
        bus.pkt_type       <= type_d;
        bus.Packet_To_Node <= payload_d;
        bus.bad_decode     <= bad_d;
        bus.corrected      <= corr_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_codec.sv
// ============================================================================
// Module      : tb_packet_codec
// Description : Self-checking bench for packet_codec with directed and random
//               fault-injection stimulus against a behavioural line-word model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_packet_codec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  packet_codec_if bus();
  packet_codec dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_chk_pos(input int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 8) || (p == 16);
  endfunction

  // Line-word model built directly from the layout rules.
  function automatic logic [54:0] model_encode(input logic [28:0] pkt);
    logic [2:0]  t;
    logic [29:0] cw;
    logic        b;
    int          p;
    t  = pkt[28] ? 3'b100 : 3'b001;
    cw = '0;
    p  = 1;
    for (int i = 0; i < 24; i++) begin
      while (is_chk_pos(p)) p++;
      cw[p-1] = pkt[i];
      p++;
    end
    for (int k = 0; k < 5; k++) begin
      b = 1'b0;
      for (int q = 1; q <= 29; q++)
        if (!is_chk_pos(q) && ((q >> k) & 1) == 1) b ^= cw[q-1];
      cw[(1 << k) - 1] = b;
    end
    cw[29] = ^cw[28:0];
    return {4'b1011, {3{t}}, {3{pkt[27:24]}}, cw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] ea, input logic [2:0] et,
                         input logic [23:0] ep, input bit chk_pl, input logic eb, input logic ec);
    chk({tag, ".dvalid"}, 64'(bus.dec_valid_out), 64'd1);
    chk({tag, ".addr"}, 64'(bus.addr), 64'(ea));
    chk({tag, ".type"}, 64'(bus.pkt_type), 64'(et));
    if (chk_pl) chk({tag, ".payload"}, 64'(bus.Packet_To_Node), 64'(ep));
    chk({tag, ".bad"}, 64'(bus.bad_decode), 64'(eb));
    chk({tag, ".corr"}, 64'(bus.corrected), 64'(ec));
  endtask

  // Random word with known injected faults; expectations follow from the faults.
  task automatic gen_rx(output logic [54:0] w, output logic [3:0] ea, output logic [2:0] et,
                        output logic [23:0] ep, output logic eb, output logic ec);
    logic [28:0] pkt;
    int nflip, f0, f1, hdr, cp;
    pkt   = 29'($urandom);
    w     = model_encode(pkt);
    ea    = pkt[27:24];
    et    = pkt[28] ? 3'b100 : 3'b001;
    ep    = pkt[23:0];
    nflip = $urandom_range(0, 2);
    f0    = $urandom_range(0, 29);
    f1    = (f0 + $urandom_range(1, 29)) % 30;
    if (nflip >= 1) w[f0] = ~w[f0];
    if (nflip == 2) w[f1] = ~w[f1];
    hdr = $urandom_range(0, 2);
    cp  = $urandom_range(0, 2);
    if (hdr == 1) w[42 + 3*cp +: 3] = w[42 + 3*cp +: 3] ^ 3'($urandom_range(1, 7));
    if (hdr == 2) w[30 + 4*cp +: 4] = w[30 + 4*cp +: 4] ^ 4'($urandom_range(1, 15));
    eb = (nflip == 2);
    ec = (nflip == 1) || (hdr != 0);
  endtask

  logic [54:0] w, exp_pkt;
  logic [28:0] pkt;
  logic [3:0]  ea;
  logic [2:0]  et;
  logic [23:0] ep;
  logic        eb, ec;

  initial begin
    rst_n = 1'b1;
    bus.Packet_From_Node = '0;
    bus.enc_valid_in     = 1'b0;
    bus.RX_Data          = '0;
    bus.dec_valid_in     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst.packet", 64'(bus.packet), 64'd0);
    chk("rst.evalid", 64'(bus.enc_valid_out), 64'd0);
    chk("rst.dvalid", 64'(bus.dec_valid_out), 64'd0);
    chk("rst.bad", 64'(bus.bad_decode), 64'd0);

    // Round trips: encoder output checked, then looped into the decoder.
    for (int r = 0; r < 2; r++) begin
      pkt = (r == 0) ? 29'h109F05AC : 29'h119F05AC;
      bus.Packet_From_Node = pkt;
      bus.enc_valid_in = 1'b1;
      tick();
      bus.enc_valid_in = 1'b0;
      chk("rt.packet", 64'(bus.packet), 64'(model_encode(pkt)));
      chk("rt.evalid", 64'(bus.enc_valid_out), 64'd1);
      bus.RX_Data = bus.packet;
      bus.dec_valid_in = 1'b1;
      tick();
      chk_dec("rt", 4'(r), 3'b100, 24'h9F05AC, 1, 1'b0, 1'b0);
    end

    exp_pkt = model_encode(29'h119F05AC);
    for (int i = 0; i < 30; i++) begin
      w = exp_pkt;
      w[i] = ~w[i];
      bus.RX_Data = w;
      tick();
      chk_dec($sformatf("flip%0d", i), 4'd1, 3'b100, 24'h9F05AC, 1, 1'b0, 1'b1);
    end

    w = exp_pkt;
    w[5] = ~w[5];
    w[17] = ~w[17];
    bus.RX_Data = w;
    tick();
    chk_dec("dbl", 4'd1, 3'b100, 24'h0, 0, 1'b1, 1'b0);

    for (int c = 0; c < 3; c++) begin
      w = exp_pkt;
      w[30 + 4*c +: 4] = 4'hE;
      bus.RX_Data = w;
      tick();
      chk_dec($sformatf("addrcp%0d", c), 4'd1, 3'b100, 24'h9F05AC, 1, 1'b0, 1'b1);
      w = exp_pkt;
      w[42 + 3*c +: 3] = 3'b011;
      bus.RX_Data = w;
      tick();
      chk_dec($sformatf("typecp%0d", c), 4'd1, 3'b100, 24'h9F05AC, 1, 1'b0, 1'b1);
    end

    bus.RX_Data = 55'h289f05acb00000;
    tick();
    chk("badsync.bad", 64'(bus.bad_decode), 64'd1);

    w = exp_pkt;
    w[50:42] = 9'h1FF;
    bus.RX_Data = w;
    tick();
    chk("type7.type", 64'(bus.pkt_type), 64'h7);
    chk("type7.bad", 64'(bus.bad_decode), 64'd1);

    // Random concurrent traffic on both paths.
    bus.enc_valid_in = 1'b1;
    for (int n = 0; n < 40; n++) begin
      pkt = 29'($urandom);
      bus.Packet_From_Node = pkt;
      gen_rx(w, ea, et, ep, eb, ec);
      bus.RX_Data = w;
      tick();
      chk("rnd.packet", 64'(bus.packet), 64'(model_encode(pkt)));
      chk_dec("rnd", ea, et, ep, !eb, eb, ec);
    end

    // Bursts of four with idle gaps: results one cycle later, outputs hold.
    for (int b = 0; b < 2; b++) begin
      bus.enc_valid_in = 1'b1;
      bus.dec_valid_in = 1'b1;
      for (int n = 0; n < 4; n++) begin
        pkt = 29'($urandom);
        bus.Packet_From_Node = pkt;
        gen_rx(w, ea, et, ep, eb, ec);
        bus.RX_Data = w;
        tick();
        exp_pkt = model_encode(pkt);
        chk("burst.packet", 64'(bus.packet), 64'(exp_pkt));
        chk("burst.evalid", 64'(bus.enc_valid_out), 64'd1);
        chk_dec("burst", ea, et, ep, !eb, eb, ec);
      end
      bus.enc_valid_in = 1'b0;
      bus.dec_valid_in = 1'b0;
      bus.Packet_From_Node = 29'($urandom);
      bus.RX_Data = {$urandom, $urandom};
      for (int g = 0; g < 2; g++) begin
        tick();
        chk("gap.evalid", 64'(bus.enc_valid_out), 64'd0);
        chk("gap.dvalid", 64'(bus.dec_valid_out), 64'd0);
        chk("gap.packet", 64'(bus.packet), 64'(exp_pkt));
        chk("gap.addr", 64'(bus.addr), 64'(ea));
      end
    end

    // Asynchronous reset mid-stream.
    bus.enc_valid_in = 1'b1;
    bus.dec_valid_in = 1'b1;
    bus.Packet_From_Node = 29'h119F05AC;
    bus.RX_Data = model_encode(29'h119F05AC);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.packet", 64'(bus.packet), 64'd0);
    chk("arst.evalid", 64'(bus.enc_valid_out), 64'd0);
    chk("arst.dvalid", 64'(bus.dec_valid_out), 64'd0);
    chk("arst.addr", 64'(bus.addr), 64'd0);
    chk("arst.payload", 64'(bus.Packet_To_Node), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enc_valid_in = 1'b0;
    bus.dec_valid_in = 1'b0;
    tick();
    chk("post.evalid", 64'(bus.enc_valid_out), 64'd0);
    chk("post.dvalid", 64'(bus.dec_valid_out), 64'd0);
    bus.enc_valid_in = 1'b1;
    bus.dec_valid_in = 1'b1;
    tick();
    chk("post.packet", 64'(bus.packet), 64'(model_encode(29'h119F05AC)));
    chk_dec("post", 4'd1, 3'b100, 24'h9F05AC, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
